// File: rtl/mby_igr_pb_fifo_ctrl.sv
// rtl/mby_igr_pb_fifo_ctrl.sv - per-port PB bank circular FIFO controller
// Arbitrates ingress writes and credit-limited reads onto one single-port shell, one op per cycle.

module mby_igr_pb_fifo_ctrl #(
  parameter int DATA_W = 644,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int OBUF_D = 4,
  localparam int ADR_W = $clog2(DEPTH)
) (
  input  logic                      cclk,
  input  logic                      rst,
  input  logic [ADR_W-1:0]          cfg_max_dpth,
  input  logic                      i_flush,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [DATA_W-1:0]         i_wr_data,
  output logic                      o_rd_valid,
  input  logic                      i_rd_ready,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic [2+ADR_W+DATA_W-1:0] o_shell_ctrl,
  input  logic [DATA_W:0]           i_shell_rdata,
  output logic [ADR_W:0]            o_occ,
  output logic                      o_lat_err
);

  localparam int CRD_W = $clog2(OBUF_D + 1);
  localparam int OB_AW = (OBUF_D > 1) ? $clog2(OBUF_D) : 1;
  localparam int CNT_W = $clog2(2 * (OBUF_D + RD_LAT) + 1);

  logic [ADR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADR_W:0]    sram_cnt_q, sram_cnt_d;
  logic [CRD_W-1:0]  credits_q, credits_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              rr_q, rr_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ob_mem_q [OBUF_D];
  logic [DATA_W-1:0] ob_mem_d [OBUF_D];
  logic [OB_AW-1:0]  ob_wp_q, ob_wp_d;
  logic [OB_AW-1:0]  ob_rp_q, ob_rp_d;
  logic [CRD_W-1:0]  ob_cnt_q, ob_cnt_d;
  logic              lat_err_q, lat_err_d;

  logic [ADR_W:0]    max_cnt;
  logic              full;
  logic              wr_req;
  logic              rd_elig;
  logic              wr_gnt;
  logic              rd_gnt;
  logic              ret_vld;
  logic [DATA_W-1:0] ret_data;
  logic              ret_drop;
  logic              ret_take;
  logic              ret_bad;
  logic              ob_pop;
  logic              ob_full;
  logic              ob_ovf;
  logic              ob_push;

  function automatic logic [ADR_W-1:0] adr_nxt(input logic [ADR_W-1:0] p,
                                               input logic [ADR_W-1:0] max_adr);
    return (p == max_adr) ? '0 : p + ADR_W'(1);
  endfunction

  function automatic logic [OB_AW-1:0] ob_nxt(input logic [OB_AW-1:0] p);
    return (p == OB_AW'(OBUF_D - 1)) ? '0 : p + OB_AW'(1);
  endfunction

  assign max_cnt  = {1'b0, cfg_max_dpth} + (ADR_W + 1)'(1);
  assign full     = (sram_cnt_q == max_cnt);
  assign wr_req   = i_wr_valid & ~full;
  assign rd_elig  = (sram_cnt_q != '0) & (credits_q != '0);

  // rr set means the read side owns the next contended cycle
  assign o_wr_ready = ~rst & ~i_flush & ~full & ~(rd_elig & rr_q);
  assign wr_gnt     = i_wr_valid & o_wr_ready;
  assign rd_gnt     = rd_elig & ~i_flush & ~(wr_req & ~rr_q);

  assign ret_vld  = i_shell_rdata[DATA_W];
  assign ret_data = i_shell_rdata[DATA_W-1:0];
  assign ret_drop = ret_vld & (drop_q != '0);
  // A return with nothing outstanding has no credit behind it, so it is flagged, not buffered
  assign ret_take = ret_vld & ~ret_drop & (inflight_q != '0);
  assign ret_bad  = ret_vld & ~ret_drop & (inflight_q == '0);

  assign ob_pop   = (ob_cnt_q != '0) & i_rd_ready;
  assign ob_full  = (ob_cnt_q == CRD_W'(OBUF_D));
  assign ob_ovf   = ret_take & ob_full & ~ob_pop;
  assign ob_push  = ret_take & ~ob_ovf;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sram_cnt_d = sram_cnt_q;
    credits_d  = credits_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    rr_d       = rr_q;
    rd_en_d    = rd_gnt;
    wr_en_d    = wr_gnt;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    ob_mem_d   = ob_mem_q;
    ob_wp_d    = ob_wp_q;
    ob_rp_d    = ob_rp_q;
    ob_cnt_d   = ob_cnt_q;
    lat_err_d  = lat_err_q | ret_bad | ob_ovf;

    if (wr_gnt) begin
      wr_ptr_d = adr_nxt(wr_ptr_q, cfg_max_dpth);
      adr_d    = wr_ptr_q;
      wdata_d  = i_wr_data;
    end
    if (rd_gnt) begin
      rd_ptr_d = adr_nxt(rd_ptr_q, cfg_max_dpth);
      adr_d    = rd_ptr_q;
    end

    if (wr_gnt && !rd_gnt) begin
      sram_cnt_d = sram_cnt_q + (ADR_W + 1)'(1);
    end else if (rd_gnt && !wr_gnt) begin
      sram_cnt_d = sram_cnt_q - (ADR_W + 1)'(1);
    end

    if (rd_gnt && !ob_pop) begin
      credits_d = credits_q - CRD_W'(1);
    end else if (ob_pop && !rd_gnt) begin
      credits_d = credits_q + CRD_W'(1);
    end

    if (rd_gnt && !ret_take) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (ret_take && !rd_gnt) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    if (ret_drop) begin
      drop_d = drop_q - CNT_W'(1);
    end

    if (wr_req && rd_elig) begin
      rr_d = ~rr_q;
    end

    if (ob_push) begin
      ob_mem_d[ob_wp_q] = ret_data;
      ob_wp_d           = ob_nxt(ob_wp_q);
    end
    if (ob_pop) begin
      ob_rp_d = ob_nxt(ob_rp_q);
    end
    if (ob_push && !ob_pop) begin
      ob_cnt_d = ob_cnt_q + CRD_W'(1);
    end else if (ob_pop && !ob_push) begin
      ob_cnt_d = ob_cnt_q - CRD_W'(1);
    end

    // Reads still in the shell become drops; a return landing this cycle is already discarded
    if (i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      sram_cnt_d = '0;
      credits_d  = CRD_W'(OBUF_D);
      drop_d     = drop_d + inflight_d;
      inflight_d = '0;
      rr_d       = 1'b0;
      ob_wp_d    = '0;
      ob_rp_d    = '0;
      ob_cnt_d   = '0;
    end
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      credits_q  <= CRD_W'(OBUF_D);
      inflight_q <= '0;
      drop_q     <= '0;
      rr_q       <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      for (int i = 0; i < OBUF_D; i++) begin
        ob_mem_q[i] <= '0;
      end
      ob_wp_q    <= '0;
      ob_rp_q    <= '0;
      ob_cnt_q   <= '0;
      lat_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rr_q       <= rr_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      for (int i = 0; i < OBUF_D; i++) begin
        ob_mem_q[i] <= ob_mem_d[i];
      end
      ob_wp_q    <= ob_wp_d;
      ob_rp_q    <= ob_rp_d;
      ob_cnt_q   <= ob_cnt_d;
      lat_err_q  <= lat_err_d;
    end
  end

  assign o_shell_ctrl = {rd_en_q, wr_en_q, adr_q, wdata_q};
  assign o_rd_valid   = (ob_cnt_q != '0);
  assign o_rd_data    = ob_mem_q[ob_rp_q];
  assign o_occ        = sram_cnt_q;
  assign o_lat_err    = lat_err_q;

endmodule

// File: tb/tb_mby_igr_pb_fifo_ctrl.sv
// tb/tb_mby_igr_pb_fifo_ctrl.sv - scoreboard bench for mby_igr_pb_fifo_ctrl with a bank shell model

module tb_mby_igr_pb_fifo_ctrl;

  localparam int DATA_W = 644;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int OBUF_D = 4;
  localparam int ADR_W  = 10;
  localparam int CTRL_W = 2 + ADR_W + DATA_W;

  logic              cclk = 1'b0;
  logic              rst;
  logic [ADR_W-1:0]  cfg_max_dpth;
  logic              i_flush;
  logic              i_wr_valid;
  logic              o_wr_ready;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_rd_valid;
  logic              i_rd_ready;
  logic [DATA_W-1:0] o_rd_data;
  logic [CTRL_W-1:0] o_shell_ctrl;
  logic [DATA_W:0]   i_shell_rdata;
  logic [ADR_W:0]    o_occ;
  logic              o_lat_err;

  always #5 cclk = ~cclk;

  mby_igr_pb_fifo_ctrl dut (
    .cclk          (cclk),
    .rst           (rst),
    .cfg_max_dpth  (cfg_max_dpth),
    .i_flush       (i_flush),
    .i_wr_valid    (i_wr_valid),
    .o_wr_ready    (o_wr_ready),
    .i_wr_data     (i_wr_data),
    .o_rd_valid    (o_rd_valid),
    .i_rd_ready    (i_rd_ready),
    .o_rd_data     (o_rd_data),
    .o_shell_ctrl  (o_shell_ctrl),
    .i_shell_rdata (i_shell_rdata),
    .o_occ         (o_occ),
    .o_lat_err     (o_lat_err)
  );

  logic              sh_rd, sh_wr;
  logic [ADR_W-1:0]  sh_adr;
  logic [DATA_W-1:0] sh_wd;
  assign sh_rd  = o_shell_ctrl[CTRL_W-1];
  assign sh_wr  = o_shell_ctrl[CTRL_W-2];
  assign sh_adr = o_shell_ctrl[DATA_W +: ADR_W];
  assign sh_wd  = o_shell_ctrl[DATA_W-1:0];

  // Bank shell: samples the ctrl bus each edge, returns read data RD_LAT cycles later
  logic [DATA_W-1:0] mem [DEPTH];
  logic [RD_LAT-1:0] pv = '0;
  logic [DATA_W-1:0] pd [RD_LAT];
  logic              inj = 1'b0;

  always @(posedge cclk) begin
    if (sh_wr) mem[sh_adr] <= sh_wd;
    if (rst) pv <= '0;
    else     pv <= {pv[RD_LAT-2:0], sh_rd};
    pd[0] <= mem[sh_adr];
    for (int k = 1; k < RD_LAT; k++) pd[k] <= pd[k-1];
  end
  assign i_shell_rdata = {pv[RD_LAT-1] | inj, pd[RD_LAT-1]};

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk_i(input string name, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic chk_d(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic fail(input string name);
    chk_cnt++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [31:0] s);
    logic [DATA_W+31:0] t;
    t = '0;
    for (int i = 0; i < 21; i++) t = {t[DATA_W-1:0], s};
    return t[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] wd_q [$];
  int                wadr_q [$];
  int                exp_wptr = 0;
  int                exp_rptr = 0;
  int                rd_issued = 0;
  int                rv_seen = 0;
  int                seq = 0;

  // Output and shell monitor
  always @(negedge cclk) begin
    if (!rst) begin
      if (o_rd_valid && i_rd_ready) begin
        if (exp_q.size() == 0) fail("rd_unexpected");
        else chk_d("rd_data", o_rd_data, exp_q.pop_front());
      end
      if (sh_wr && sh_rd) fail("shell_rd_and_wr");
      if (sh_wr) begin
        if (wadr_q.size() == 0) fail("shell_wr_unexpected");
        else begin
          chk_i("shell_wr_adr", int'(sh_adr), wadr_q.pop_front());
          chk_d("shell_wr_data", sh_wd, wd_q.pop_front());
        end
      end
      if (sh_rd) begin
        chk_i("shell_rd_adr", int'(sh_adr), exp_rptr);
        exp_rptr = (exp_rptr == int'(cfg_max_dpth)) ? 0 : exp_rptr + 1;
        rd_issued++;
      end
      if (i_shell_rdata[DATA_W]) rv_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge cclk);
      #1;
    end
  endtask

  task automatic send(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = mk(32'h1000_0000 + seq);
      w = 0;
      @(negedge cclk);
      while (!o_wr_ready && w < 500) begin
        w++;
        @(negedge cclk);
      end
      if (!o_wr_ready) fail("send_timeout");
      else begin
        exp_q.push_back(i_wr_data);
        wd_q.push_back(i_wr_data);
        wadr_q.push_back(exp_wptr);
        exp_wptr = (exp_wptr == int'(cfg_max_dpth)) ? 0 : exp_wptr + 1;
        seq++;
      end
      @(posedge cclk);
      #1;
    end
    i_wr_valid = 1'b0;
  endtask

  task automatic flush(input int cfg);
    i_flush      = 1'b1;
    cfg_max_dpth = ADR_W'(cfg);
    step(1);
    i_flush  = 1'b0;
    exp_q.delete();
    wd_q.delete();
    wadr_q.delete();
    exp_wptr = 0;
    exp_rptr = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_rd_valid) && n < 1000) begin
      step(1);
      n++;
    end
    chk_i(name, exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int n, base, blocked, viol, prev_wr, rdv_cnt, occ_bad, rv_base;

  initial begin
    rst          = 1'b1;
    cfg_max_dpth = ADR_W'(DEPTH - 1);
    i_flush      = 1'b0;
    i_wr_valid   = 1'b1;
    i_wr_data    = '0;
    i_rd_ready   = 1'b0;
    step(3);
    chk_d("rst_shell_ctrl", o_shell_ctrl[DATA_W-1:0], '0);
    chk_i("rst_shell_top", int'(o_shell_ctrl[CTRL_W-1:DATA_W]), 0);
    chk_i("rst_rd_valid", int'(o_rd_valid), 0);
    chk_i("rst_occ", int'(o_occ), 0);
    chk_i("rst_lat_err", int'(o_lat_err), 0);
    chk_i("rst_wr_ready", int'(o_wr_ready), 0);
    i_wr_valid = 1'b0;
    rst = 1'b0;
    step(2);

    // single write then read, latency and occupancy
    i_rd_ready = 1'b1;
    seq = 32'h0A5A5A5A5 - 32'h1000_0000;
    send(1);
    chk_i("t1_occ_after_wr", int'(o_occ), 1);
    chk_i("t1_wr_en", int'(sh_wr), 1);
    chk_i("t1_wr_adr", int'(sh_adr), 0);
    n = 0;
    while (!o_rd_valid && n < 50) begin
      step(1);
      n++;
    end
    chk_i("t1_latency", n, RD_LAT + 2);
    chk_d("t1_head_data", o_rd_data, mk(32'hA5A5A5A5));
    chk_i("t1_occ_after_rd", int'(o_occ), 0);
    drain("t1_drain");

    // wrap and full at cfg_max_dpth = 7 with reads stalled
    i_rd_ready = 1'b0;
    flush(7);
    send(8);
    send(1);
    chk_i("t2_ninth_wr_en", int'(sh_wr), 1);
    chk_i("t2_ninth_wr_adr", int'(sh_adr), 0);
    send(3);
    step(6);
    chk_i("t2_occ_full", int'(o_occ), 8);
    chk_i("t2_obuf_valid", int'(o_rd_valid), 1);
    i_wr_valid = 1'b1;
    i_wr_data  = mk(32'hDEAD0000);
    blocked = 0;
    repeat (4) begin
      @(negedge cclk);
      if (!o_wr_ready) blocked++;
    end
    chk_i("t2_full_blocks", blocked, 4);
    @(posedge cclk);
    #1;
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b1;
    send(1);
    drain("t2_drain");
    chk_i("t2_occ_empty", int'(o_occ), 0);

    // continuous streaming alternates write/read every cycle
    flush(DEPTH - 1);
    viol = 0;
    prev_wr = 0;
    fork
      send(120);
      begin
        repeat (10) @(negedge cclk);
        prev_wr = int'(sh_wr);
        repeat (100) begin
          @(negedge cclk);
          if ((int'(sh_wr) + int'(sh_rd)) != 1 || int'(sh_wr) == prev_wr) viol++;
          prev_wr = int'(sh_wr);
        end
      end
    join
    chk_i("t3_alternation_viol", viol, 0);
    drain("t3_drain");

    // credit limit: 14 writes, consumer stalled
    i_rd_ready = 1'b0;
    flush(DEPTH - 1);
    base = rd_issued;
    send(14);
    step(10);
    chk_i("t4_reads_at_credit_limit", rd_issued - base, OBUF_D);
    chk_i("t4_occ", int'(o_occ), 10);
    i_rd_ready = 1'b1;
    drain("t4_drain");
    chk_i("t4_reads_total", rd_issued - base, 14);

    // flush with two reads in flight
    flush(DEPTH - 1);
    send(2);
    step(2);
    i_flush = 1'b1;
    step(1);
    i_flush = 1'b0;
    exp_q.delete();
    wd_q.delete();
    wadr_q.delete();
    exp_wptr = 0;
    exp_rptr = 0;
    rv_base = rv_seen;
    rdv_cnt = 0;
    occ_bad = 0;
    repeat (10) begin
      @(negedge cclk);
      if (o_rd_valid) rdv_cnt++;
      if (o_occ != 0) occ_bad++;
    end
    chk_i("t5_dropped_returns", rv_seen - rv_base, 2);
    chk_i("t5_rd_valid_cycles", rdv_cnt, 0);
    chk_i("t5_occ_nonzero_cycles", occ_bad, 0);
    chk_i("t5_lat_err", int'(o_lat_err), 0);
    @(posedge cclk);
    #1;
    send(1);
    chk_i("t5_post_flush_adr", int'(sh_adr), 0);
    drain("t5_drain");
    chk_i("t5_lat_err_end", int'(o_lat_err), 0);

    // unexpected return sets sticky error
    step(3);
    inj = 1'b1;
    step(1);
    inj = 1'b0;
    chk_i("t6_lat_err_set", int'(o_lat_err), 1);
    step(5);
    chk_i("t6_lat_err_sticky", int'(o_lat_err), 1);
    rst = 1'b1;
    #1;
    chk_i("t6_lat_err_rst", int'(o_lat_err), 0);
    chk_i("t6_wr_ready_rst", int'(o_wr_ready), 0);
    step(2);
    rst = 1'b0;
    exp_q.delete();
    wd_q.delete();
    wadr_q.delete();
    exp_wptr = 0;
    exp_rptr = 0;
    step(1);
    send(1);
    chk_i("t6_post_rst_adr", int'(sh_adr), 0);
    drain("t6_drain");
    chk_i("t6_lat_err_final", int'(o_lat_err), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
